// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file sizing constants and index type.
package rf_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NREGS    = 32;
   localparam int ZERO_REG = 0;
   typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write-back request and dual read-port bundle of the register file.
interface reg_file_if
   import rf_pkg::*;
#(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W
);
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;
   logic              WbPending;
   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2, WbPending
   );
   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2, WbPending
   );
endinterface

// File: rtl/reg_file_dec.sv
// reg_file_dec: one-hot array write-enable decoder; entry 0 is never enabled.
module reg_file_dec
   import rf_pkg::*;
#(
   parameter int ADDR_W = rf_pkg::ADDR_W,
   parameter int NREGS  = rf_pkg::NREGS
) (
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic [NREGS-1:0]  we
);
   assign we[0] = 1'b0;
   for (genvar g = 1; g < NREGS; g++) begin : g_we
      assign we[g] = wb_en && (wb_addr == ADDR_W'(g));
   end
endmodule

// File: rtl/reg_file.sv
// reg_file: two-read one-write register file with a one-cycle commit stage
// bypassed onto both read ports; register 0 is hard-wired to zero.
module reg_file
   import rf_pkg::*;
#(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W,
   parameter int NREGS  = rf_pkg::NREGS
) (
   input  logic     clk,
   input  logic     rst_n,
   reg_file_if.slave bus
);
   logic              wb_en_q,   wb_en_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];
   logic [NREGS-1:0]  we;
   reg_file_dec #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_dec (
      .wb_en   (wb_en_q),
      .wb_addr (wb_addr_q),
      .we      (we)
   );
   // Writes to register 0 are dropped here so they never pend or bypass.
   always_comb begin
      wb_en_d   = bus.RegWrite && (bus.WriteRegister != ADDR_W'(ZERO_REG));
      wb_addr_d = bus.WriteRegister;
      wb_data_d = bus.WriteData;
      for (int i = 0; i < NREGS; i++) mem_d[i] = we[i] ? wb_data_q : mem_q[i];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
      end
   end
   assign bus.ReadData1 = (bus.ReadRegister1 == ADDR_W'(ZERO_REG)) ? '0 :
                          (wb_en_q && wb_addr_q == bus.ReadRegister1) ? wb_data_q :
                          mem_q[bus.ReadRegister1];
   assign bus.ReadData2 = (bus.ReadRegister2 == ADDR_W'(ZERO_REG)) ? '0 :
                          (wb_en_q && wb_addr_q == bus.ReadRegister2) ? wb_data_q :
                          mem_q[bus.ReadRegister2];
   assign bus.WbPending = wb_en_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench; the driver queues expected read-port values
// per cycle and a negedge monitor compares them against the DUT.
module tb_reg_file;
   import rf_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_if bus ();
   reg_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      string       nm;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        ep;
   } exp_t;
   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] m_mem [32];
   logic        m_en = 1'b0;
   reg_idx_t    m_addr = '0;
   logic [31:0] m_data = '0;

   function automatic logic [31:0] m_read(input reg_idx_t idx);
      if (idx == 5'd0) return 32'd0;
      if (m_en && m_addr == idx) return m_data;
      return m_mem[idx];
   endfunction

   task automatic step(input logic rs, input logic wr, input reg_idx_t wa, input logic [31:0] wd,
                       input reg_idx_t r1, input reg_idx_t r2, input logic chk,
                       input logic [31:0] e1, input logic [31:0] e2, input logic ep, input string nm);
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
         m_en = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         if (m_en) m_mem[m_addr] = m_data;
         m_en = bus.RegWrite && (bus.WriteRegister != 5'd0);
         m_addr = bus.WriteRegister;
         m_data = bus.WriteData;
      end
      #1;
      rst_n = rs;
      bus.RegWrite = wr;
      bus.WriteRegister = wa;
      bus.WriteData = wd;
      bus.ReadRegister1 = r1;
      bus.ReadRegister2 = r2;
      if (chk) q.push_back('{nm, e1, e2, ep});
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (bus.ReadData1 !== e.e1 || bus.ReadData2 !== e.e2 || bus.WbPending !== e.ep) begin
               n_fail++;
               $display("FAIL %s: got rd1=%h rd2=%h pend=%b, expected rd1=%h rd2=%h pend=%b",
                        e.nm, bus.ReadData1, bus.ReadData2, bus.WbPending, e.e1, e.e2, e.ep);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      bus.RegWrite = 1'b1;
      bus.WriteRegister = 5'd3;
      bus.WriteData = 32'hAAAA_AAAA;
      bus.ReadRegister1 = 5'd0;
      bus.ReadRegister2 = 5'd0;
      // RegWrite held high through reset must not leave r3 written.
      step(0, 1, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd3, 0, 0, 0, 0, "");
      step(0, 1, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd3, 0, 0, 0, 0, "");
      for (int i = 0; i < 32; i++)
         step(1, 0, 5'd0, 32'd0, reg_idx_t'(i), reg_idx_t'(31 - i), 1, 32'd0, 32'd0, 1'b0, "reset_read");
      step(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1, 32'd0, 32'd0, 1'b0, "r5_no_fwd");
      step(1, 0, 5'd0, 32'd0, 5'd5, 5'd5, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, "r5_bypass");
      step(1, 0, 5'd0, 32'd0, 5'd5, 5'd5, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "r5_array");
      step(1, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1, 32'd0, 32'd0, 1'b0, "r0_write");
      step(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 32'd0, 32'd0, 1'b0, "r0_hold1");
      step(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 32'd0, 32'd0, 1'b0, "r0_hold2");
      step(1, 1, 5'd7, 32'h1111_1111, 5'd7, 5'd7, 1, 32'd0, 32'd0, 1'b0, "r7_first");
      step(1, 1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 1, 32'h1111_1111, 32'h1111_1111, 1'b1, "r7_second");
      step(1, 0, 5'd0, 32'd0, 5'd7, 5'd7, 1, 32'h2222_2222, 32'h2222_2222, 1'b1, "r7_bypass");
      step(1, 0, 5'd0, 32'd0, 5'd7, 5'd7, 1, 32'h2222_2222, 32'h2222_2222, 1'b0, "r7_array");
      step(1, 0, 5'd0, 32'd0, 5'd7, 5'd5, 1, 32'h2222_2222, 32'hDEAD_BEEF, 1'b0, "r7_r5");
      step(1, 1, 5'd9, 32'h1234_5678, 5'd9, 5'd9, 1, 32'd0, 32'd0, 1'b0, "r9_write");
      step(0, 0, 5'd0, 32'd0, 5'd9, 5'd9, 1, 32'h1234_5678, 32'h1234_5678, 1'b1, "r9_pre_rst");
      step(1, 0, 5'd0, 32'd0, 5'd9, 5'd5, 1, 32'd0, 32'd0, 1'b0, "r9_post_rst");
      step(1, 0, 5'd0, 32'd0, 5'd7, 5'd9, 1, 32'd0, 32'd0, 1'b0, "r9_dropped");
      for (int i = 0; i < 10000; i++) begin
         logic rs, wr;
         reg_idx_t wa, r1, r2;
         logic [31:0] wd;
         rs = ($urandom_range(0, 199) != 0);
         wr = 1'($urandom_range(0, 1));
         wa = reg_idx_t'($urandom_range(0, 31));
         wd = $urandom;
         r1 = ($urandom_range(0, 3) == 0) ? wa : reg_idx_t'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? r1 : reg_idx_t'($urandom_range(0, 31));
         step(rs, wr, wa, wd, r1, r2, 0, 0, 0, 0, "");
         q.push_back('{"random", m_read(r1), m_read(r2), m_en});
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
